// File: rtl/ca_correlator_if.sv
// ca_correlator_if - sample/chip input bus and dump read-out bus of the
// E/P/L correlator. The slave side is the correlator; the master side is
// the cacode/sample source together with the CPU PIO reader.
// Optional: CA_CORR_SAT_EN adds the sat_flag read-out bit.
interface ca_correlator_if #(
  parameter int SAMPLE_W = 2,
  parameter int ACC_W    = 16,
  parameter int CNT_W    = 12
);
  logic                       enable;
  logic                       samp_valid;
  logic signed [SAMPLE_W-1:0] samp_i;
  logic signed [SAMPLE_W-1:0] samp_q;
  logic                       chip;
  logic                       epoch;
  logic                       dump_valid;
  logic                       dump_ack;
  logic signed [ACC_W-1:0]    e_i, e_q, p_i, p_q, l_i, l_q;
  logic [CNT_W-1:0]           dump_cnt;
  logic                       overrun;
`ifdef CA_CORR_SAT_EN
  logic                       sat_flag;
`endif

  modport master (
    output enable, samp_valid, samp_i, samp_q, chip, epoch, dump_ack,
`ifdef CA_CORR_SAT_EN
    input  sat_flag,
`endif
    input  dump_valid, e_i, e_q, p_i, p_q, l_i, l_q, dump_cnt, overrun
  );

  modport slave (
    input  enable, samp_valid, samp_i, samp_q, chip, epoch, dump_ack,
`ifdef CA_CORR_SAT_EN
    output sat_flag,
`endif
    output dump_valid, e_i, e_q, p_i, p_q, l_i, l_q, dump_cnt, overrun
  );
endinterface

// File: rtl/ca_correlator.sv
// ca_correlator - Early/Prompt/Late accumulate-and-dump correlator that sits
// behind cacode. Six lanes (E/P/L x I/Q) accumulate one code period between
// epoch strobes; the pre-epoch totals are latched into dump registers read
// by the CPU through a valid/ack handshake.
// Optional: define CA_CORR_SAT_EN for saturating accumulators and sat_flag.
// The bus interface must be instantiated with the same SAMPLE_W/ACC_W/CNT_W.
module ca_correlator #(
  parameter int SAMPLE_W = 2,
  parameter int ACC_W    = 16,
  parameter int SPACING  = 2,
  parameter int CNT_W    = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  ca_correlator_if.slave bus
);
  // lane order: 0 e_i, 1 e_q, 2 p_i, 3 p_q, 4 l_i, 5 l_q
  localparam int NUM_LANES = 6;
  // the live chip is tap 0, so 2*SPACING registers complete the
  // 2*SPACING+1 tap line; tap k is the chip from k valid samples ago
  localparam int DL_W      = 2 * SPACING;

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, ACCUM = 2'd2} state_t;

  state_t                          r_state, w_state_nxt;
  logic [DL_W-1:0]                 r_dl;
  logic [DL_W:0]                   w_taps;
  logic                            w_clr, w_shift, w_load, w_add, w_dump;
  logic [NUM_LANES-1:0][ACC_W-1:0] w_acc;
  logic [NUM_LANES-1:0][ACC_W-1:0] r_dump;
  logic [CNT_W-1:0]                r_cnt, r_dump_cnt;
  logic                            r_dv, r_ovr;
`ifdef CA_CORR_SAT_EN
  logic [NUM_LANES-1:0]            w_lane_sat;
  logic                            r_sat_run, r_sat_flag;
`endif

  assign w_taps = {r_dl, bus.chip};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state and per-cycle datapath strobes; enable low wins everywhere
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = (r_state == IDLE);
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_dump      = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = SYNC;
        SYNC: begin
          if (bus.samp_valid) begin
            w_shift = 1'b1;
            if (bus.epoch) begin
              w_load      = 1'b1;
              w_state_nxt = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (bus.samp_valid) begin
            w_shift = 1'b1;
            if (bus.epoch) begin
              w_load = 1'b1;
              w_dump = 1'b1;
            end else begin
              w_add = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // chip delay line, advances once per valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_dl <= '0;
    else if (w_clr)   r_dl <= '0;
    else if (w_shift) r_dl <= w_taps[DL_W-1:0];
  end

  // per-period sample counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_clr)  r_cnt <= '0;
    else if (w_load) r_cnt <= CNT_W'(1);
    else if (w_add && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int TAP = (g / 2) * SPACING;
    logic [SAMPLE_W-1:0] w_samp;
    logic [SAMPLE_W:0]   w_ext, w_prod;
    logic [ACC_W-1:0]    w_prod_acc, w_sum, r_acc;

    if (g % 2 == 0) begin : g_i
      assign w_samp = bus.samp_i;
    end else begin : g_q
      assign w_samp = bus.samp_q;
    end

    // one guard bit before negation keeps -(-2^(W-1)) exact
    assign w_ext      = {w_samp[SAMPLE_W-1], w_samp};
    assign w_prod     = w_taps[TAP] ? -w_ext : w_ext;
    assign w_prod_acc = {{(ACC_W-SAMPLE_W-1){w_prod[SAMPLE_W]}}, w_prod};

`ifdef CA_CORR_SAT_EN
    logic [ACC_W:0] w_wide;
    assign w_wide        = {r_acc[ACC_W-1], r_acc} + {w_prod_acc[ACC_W-1], w_prod_acc};
    assign w_lane_sat[g] = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_sum = !w_lane_sat[g] ? w_wide[ACC_W-1:0] :
                   (w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
`else
    assign w_sum = r_acc + w_prod_acc;
`endif

    // lane accumulator: epoch sample reloads, others add
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_acc <= '0;
      else if (w_clr)  r_acc <= '0;
      else if (w_load) r_acc <= w_prod_acc;
      else if (w_add)  r_acc <= w_sum;
    end

    assign w_acc[g] = r_acc;
  end

`ifdef CA_CORR_SAT_EN
  // remembers whether any lane clipped during the running period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sat_run <= 1'b0;
    else if (w_clr)  r_sat_run <= 1'b0;
    else if (w_load) r_sat_run <= 1'b0;
    else if (w_add)  r_sat_run <= r_sat_run | (|w_lane_sat);
  end
`endif

  // dump registers and handshake; a dump into an unread slot is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dump     <= '0;
      r_dump_cnt <= '0;
      r_dv       <= 1'b0;
      r_ovr      <= 1'b0;
`ifdef CA_CORR_SAT_EN
      r_sat_flag <= 1'b0;
`endif
    end else begin
      if (w_dump) begin
        if (!r_dv || bus.dump_ack) begin
          r_dump     <= w_acc;
          r_dump_cnt <= r_cnt;
          r_dv       <= 1'b1;
`ifdef CA_CORR_SAT_EN
          r_sat_flag <= r_sat_run;
`endif
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (bus.dump_ack) begin
        r_dv <= 1'b0;
      end
      if (w_clr) r_ovr <= 1'b0;
    end
  end

  assign bus.dump_valid = r_dv;
  assign bus.e_i        = r_dump[0];
  assign bus.e_q        = r_dump[1];
  assign bus.p_i        = r_dump[2];
  assign bus.p_q        = r_dump[3];
  assign bus.l_i        = r_dump[4];
  assign bus.l_q        = r_dump[5];
  assign bus.dump_cnt   = r_dump_cnt;
  assign bus.overrun    = r_ovr;
`ifdef CA_CORR_SAT_EN
  assign bus.sat_flag   = r_sat_flag;
`endif
endmodule

// File: tb/tb_ca_correlator.sv
// tb_ca_correlator - directed test of ca_correlator. A 16-bit accumulator
// instance carries the main sequence; a 4-bit instance shares the inputs
// and is checked on the 20-sample wrap/saturation period at the end.
module tb_ca_correlator;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [1:0] P1 = 2'b01;  // +1
  localparam logic [1:0] M1 = 2'b11;  // -1
  localparam logic [1:0] M2 = 2'b10;  // -2
  localparam logic [1:0] Z  = 2'b00;

  ca_correlator_if #(.SAMPLE_W(2), .ACC_W(16), .CNT_W(12)) ifc ();
  ca_correlator_if #(.SAMPLE_W(2), .ACC_W(4),  .CNT_W(12)) ifc4 ();

  ca_correlator #(.SAMPLE_W(2), .ACC_W(16), .SPACING(2), .CNT_W(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc));
  ca_correlator #(.SAMPLE_W(2), .ACC_W(4), .SPACING(2), .CNT_W(12)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4));

  assign ifc4.enable     = ifc.enable;
  assign ifc4.samp_valid = ifc.samp_valid;
  assign ifc4.samp_i     = ifc.samp_i;
  assign ifc4.samp_q     = ifc.samp_q;
  assign ifc4.chip       = ifc.chip;
  assign ifc4.epoch      = ifc.epoch;
  assign ifc4.dump_ack   = ifc.dump_ack;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then sample 1ns after the edge
  task automatic cyc(input logic v, input logic [1:0] si, input logic [1:0] sq,
                     input logic c, input logic e, input logic a);
    ifc.samp_valid = v;
    ifc.samp_i     = si;
    ifc.samp_q     = sq;
    ifc.chip       = c;
    ifc.epoch      = e;
    ifc.dump_ack   = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    ifc.enable = 1'b0;
    cyc(1'b0, Z, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, Z, Z, 1'b0, 1'b0, 1'b0);
    chk("rst_dump_valid", ifc.dump_valid, 0);
    chk("rst_p_i",        ifc.p_i, 0);
    chk("rst_dump_cnt",   ifc.dump_cnt, 0);
    chk("rst_overrun",    ifc.overrun, 0);

    rst_n      = 1'b1;
    ifc.enable = 1'b1;
    cyc(1'b0, Z, Z, 1'b0, 1'b0, 1'b0);              // IDLE -> SYNC

    // constant chip 0, i=+1 q=-1, 10 samples per period
    cyc(1'b1, P1, M1, 1'b0, 1'b1, 1'b0);             // first epoch: load
    repeat (9) cyc(1'b1, P1, M1, 1'b0, 1'b0, 1'b0);
    chk("t1_pre_valid", ifc.dump_valid, 0);
    cyc(1'b1, P1, M1, 1'b0, 1'b1, 1'b0);             // second epoch: dump
    chk("t1_valid", ifc.dump_valid, 1);
    chk("t1_e_i", ifc.e_i, 10);
    chk("t1_p_i", ifc.p_i, 10);
    chk("t1_l_i", ifc.l_i, 10);
    chk("t1_e_q", ifc.e_q, -10);
    chk("t1_p_q", ifc.p_q, -10);
    chk("t1_l_q", ifc.l_q, -10);
    chk("t1_cnt", ifc.dump_cnt, 10);
    cyc(1'b0, Z, Z, 1'b0, 1'b0, 1'b1);               // ack
    chk("t1_ack_clears", ifc.dump_valid, 0);

    // zero-valued padding with chip 1 fills the delay line with ones
    repeat (4) cyc(1'b1, Z, Z, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, M2, P1, 1'b1, 1'b1, 1'b0);             // epoch B
    chk("pad_cnt", ifc.dump_cnt, 5);
    chk("pad_e_i", ifc.e_i, 1);
    chk("pad_l_q", ifc.l_q, -1);
    cyc(1'b1, M2, P1, 1'b1, 1'b0, 1'b1);             // ack
    repeat (3) cyc(1'b1, M2, P1, 1'b1, 1'b0, 1'b0);
    // i=-2 under chip 1 on every tap: +2 per sample, exact
    cyc(1'b1, P1, Z, 1'b0, 1'b1, 1'b0);              // epoch C
    chk("neg_p_i", ifc.p_i, 10);
    chk("neg_e_i", ifc.e_i, 10);
    chk("neg_l_i", ifc.l_i, 10);
    chk("neg_p_q", ifc.p_q, -5);
    chk("neg_cnt", ifc.dump_cnt, 5);

    // period C chips 0,0,0,1,1,1 after five ones of history
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b1);              // ack
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, P1, Z, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, P1, Z, 1'b0, 1'b1, 1'b0);              // epoch D
    chk("tap_e_i", ifc.e_i, 0);
    chk("tap_p_i", ifc.p_i, 0);
    chk("tap_l_i", ifc.l_i, -2);
    chk("tap_cnt", ifc.dump_cnt, 6);

    // dump and ack on the same edge: new result loads, no overrun
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, P1, Z, 1'b0, 1'b1, 1'b1);              // epoch E + ack
    chk("same_valid", ifc.dump_valid, 1);
    chk("same_ovr",   ifc.overrun, 0);
    chk("same_cnt",   ifc.dump_cnt, 2);
    chk("same_e_i",   ifc.e_i, 2);
    chk("same_p_i",   ifc.p_i, -2);
    chk("same_l_i",   ifc.l_i, 0);

    // unread slot: the next dump is dropped and overrun sticks
    cyc(1'b1, P1, Z, 1'b0, 1'b1, 1'b0);              // epoch F, no ack
    chk("ovr_set",   ifc.overrun, 1);
    chk("ovr_valid", ifc.dump_valid, 1);
    chk("ovr_cnt",   ifc.dump_cnt, 2);
    chk("ovr_p_i",   ifc.p_i, -2);
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b1);              // ack
    chk("ovr_ack", ifc.dump_valid, 0);
    chk("ovr_sticky", ifc.overrun, 1);

    // enable drop mid-period: dump registers held, overrun cleared
    ifc.enable = 1'b0;
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, Z, Z, 1'b0, 1'b0, 1'b0);
    chk("idle_ovr",  ifc.overrun, 0);
    chk("idle_cnt",  ifc.dump_cnt, 2);
    chk("idle_p_i",  ifc.p_i, -2);
    ifc.enable = 1'b1;
    cyc(1'b0, Z, Z, 1'b0, 1'b0, 1'b0);               // IDLE -> SYNC
    repeat (2) cyc(1'b1, P1, Z, 1'b1, 1'b0, 1'b0);   // shift only
    cyc(1'b1, P1, Z, 1'b0, 1'b1, 1'b0);              // epoch G, load only
    chk("sync_no_dump", ifc.dump_valid, 0);
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, P1, Z, 1'b1, 1'b1, 1'b0);              // invalid epoch ignored
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, Z, Z, 1'b0, 1'b1, 1'b0);               // epoch H
    chk("resync_valid", ifc.dump_valid, 1);
    chk("resync_cnt",   ifc.dump_cnt, 3);
    chk("resync_e_i",   ifc.e_i, 3);
    chk("resync_p_i",   ifc.p_i, -1);
    chk("resync_l_i",   ifc.l_i, 1);

    // asynchronous reset mid-period
    cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ifc.dump_valid, 0);
    chk("arst_p_i",   ifc.p_i, 0);
    chk("arst_cnt",   ifc.dump_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, Z, Z, 1'b0, 1'b0, 1'b0);               // IDLE -> SYNC

    // 20 samples of +1: 4-bit lanes wrap to 4 or clip at 7
    cyc(1'b1, P1, Z, 1'b0, 1'b1, 1'b0);
    repeat (19) cyc(1'b1, P1, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, P1, Z, 1'b0, 1'b1, 1'b0);
    chk("w16_p_i", ifc.p_i, 20);
    chk("w16_cnt", ifc.dump_cnt, 20);
    chk("w4_cnt",  ifc4.dump_cnt, 20);
`ifdef CA_CORR_SAT_EN
    chk("w4_p_i_sat", ifc4.p_i, 7);
    chk("w4_sat_flag", ifc4.sat_flag, 1);
    chk("w16_sat_flag", ifc.sat_flag, 0);
`else
    chk("w4_p_i_wrap", ifc4.p_i, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
